// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer: drives the shared combinational ALU for a result/compare
// pass and, for redirecting instructions, a second target-address pass.
module alu_exec_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [4:0]       in_rd,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic             out_rd_we,
    output logic [WIDTH-1:0] out_rd_data,
    output logic             out_redirect,
    output logic [WIDTH-1:0] out_npc
);

    localparam logic [2:0] OP_ALUR   = 3'b000;
    localparam logic [2:0] OP_ALUI   = 3'b001;
    localparam logic [2:0] OP_LUI    = 3'b010;
    localparam logic [2:0] OP_AUIPC  = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;
    localparam logic [2:0] OP_JAL    = 3'b101;
    localparam logic [2:0] OP_JALR   = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_COPY = 4'b1111;

    localparam logic [WIDTH-1:0] LINK_STEP = WIDTH'(3'd4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP1  = 2'd1,
        OP2  = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT            stateR;
    stateT            nextStateS;
    logic [2:0]       opR;
    logic [2:0]       f3R;
    logic             f7R;
    logic [WIDTH-1:0] pcR;
    logic [WIDTH-1:0] rs1R;
    logic [WIDTH-1:0] rs2R;
    logic [WIDTH-1:0] immR;
    logic [4:0]       rdR;
    logic             takenS;
    logic             needOp2S;
    logic             writesRdS;

    assign in_ready  = (stateR == IDLE);
    assign out_valid = (stateR == DONE);
    assign out_rd    = rdR;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Bundle capture on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opR  <= 3'b000;
            f3R  <= 3'b000;
            f7R  <= 1'b0;
            pcR  <= '0;
            rs1R <= '0;
            rs2R <= '0;
            immR <= '0;
            rdR  <= 5'd0;
        end else if ((stateR == IDLE) && in_valid) begin
            opR  <= in_op;
            f3R  <= in_funct3;
            f7R  <= in_funct7b5;
            pcR  <= in_pc;
            rs1R <= in_rs1;
            rs2R <= in_rs2;
            immR <= in_imm;
            rdR  <= in_rd;
        end
    end

    // Branch outcome, valid only while the OP1 compare is on the ALU.
    always_comb begin
        takenS = 1'b0;
        case (f3R)
            3'b000:  takenS = alu_zero;
            3'b001:  takenS = ~alu_zero;
            3'b100:  takenS = alu_result[0];
            3'b101:  takenS = ~alu_result[0];
            3'b110:  takenS = alu_result[0];
            3'b111:  takenS = ~alu_result[0];
            default: takenS = 1'b0;
        endcase
    end

    assign needOp2S  = (opR == OP_JAL) || (opR == OP_JALR) || ((opR == OP_BRANCH) && takenS);
    assign writesRdS = (opR != OP_BRANCH) && (opR != OP_RSVD);

    // Next-state logic.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            IDLE:    nextStateS = in_valid ? OP1 : IDLE;
            OP1:     nextStateS = needOp2S ? OP2 : DONE;
            OP2:     nextStateS = DONE;
            DONE:    nextStateS = out_ready ? IDLE : DONE;
            default: nextStateS = IDLE;
        endcase
    end

    // ALU drive: purely from state and the latched bundle, idle outside OP1/OP2.
    always_comb begin
        alu_ctrl = 4'b0000;
        alu_in1  = '0;
        alu_in2  = '0;
        case (stateR)
            OP1: begin
                case (opR)
                    OP_ALUR: begin
                        alu_ctrl = {f7R & ((f3R == 3'b000) || (f3R == 3'b101)), f3R};
                        alu_in1  = rs1R;
                        alu_in2  = rs2R;
                    end
                    OP_ALUI: begin
                        alu_ctrl = {f7R & (f3R == 3'b101), f3R};
                        alu_in1  = rs1R;
                        alu_in2  = immR;
                    end
                    OP_LUI: begin
                        alu_ctrl = ALU_COPY;
                        alu_in2  = immR;
                    end
                    OP_AUIPC: begin
                        alu_ctrl = ALU_ADD;
                        alu_in1  = pcR;
                        alu_in2  = immR;
                    end
                    OP_JAL, OP_JALR: begin
                        alu_ctrl = ALU_ADD;
                        alu_in1  = pcR;
                        alu_in2  = LINK_STEP;
                    end
                    OP_BRANCH: begin
                        alu_ctrl = f3R[2] ? (f3R[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                        alu_in1  = rs1R;
                        alu_in2  = rs2R;
                    end
                    default: begin
                        alu_ctrl = 4'b0000;
                    end
                endcase
            end
            OP2: begin
                alu_ctrl = ALU_ADD;
                alu_in1  = (opR == OP_JALR) ? rs1R : pcR;
                alu_in2  = immR;
            end
            default: begin
                alu_ctrl = 4'b0000;
            end
        endcase
    end

    // Result registers: OP1 captures writeback and redirect decision, OP2 the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rd_data  <= '0;
            out_rd_we    <= 1'b0;
            out_redirect <= 1'b0;
            out_npc      <= '0;
        end else begin
            case (stateR)
                OP1: begin
                    out_rd_data  <= (opR == OP_RSVD) ? '0 : alu_result;
                    out_rd_we    <= writesRdS && (rdR != 5'd0);
                    out_redirect <= needOp2S;
                    out_npc      <= '0;
                end
                OP2: begin
                    out_npc <= (opR == OP_JALR) ? {alu_result[WIDTH-1:1], 1'b0} : alu_result;
                end
                default: begin
                    out_npc <= out_npc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: a bench-side ALU feeds the DUT, and a
// specification-level model predicts every transaction's outputs and timing.
module tb_alu_exec_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_rd_data;
    logic        out_redirect;
    logic [31:0] out_npc;

    int nChecks = 0;
    int nFail   = 0;

    alu_exec_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_rd_data(out_rd_data),
        .out_redirect(out_redirect), .out_npc(out_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational ALU seen by the sequencer.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_in1 + alu_in2;
            4'b1000: alu_result = alu_in1 - alu_in2;
            4'b0001: alu_result = alu_in1 << alu_in2[4:0];
            4'b0010: alu_result = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
            4'b0011: alu_result = {31'd0, alu_in1 < alu_in2};
            4'b0100: alu_result = alu_in1 ^ alu_in2;
            4'b0101: alu_result = alu_in1 >> alu_in2[4:0];
            4'b1101: alu_result = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
            4'b0110: alu_result = alu_in1 | alu_in2;
            4'b0111: alu_result = alu_in1 & alu_in2;
            4'b1111: alu_result = alu_in2;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic        redir;
        logic [31:0] npc;
        logic [1:0]  lat;
        logic [3:0]  c1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;
        logic        chkAlu1;
        logic        chkA1;
        logic        chkData;
    } expT;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RISC-V style arithmetic selected by funct3 and the alternate bit.
    function automatic logic [31:0] f3Arith(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic expT model(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] pc, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm,
                                  input logic [4:0] rd);
        expT e;
        logic alt;
        logic taken;
        e = '0;
        e.lat = 2'd2;
        e.chkAlu1 = 1'b1;
        e.chkA1 = 1'b1;
        e.chkData = 1'b1;
        case (op)
            3'd0: begin
                alt = f7 && (f3 == 3'd0 || f3 == 3'd5);
                e.c1 = {alt, f3}; e.a1 = rs1; e.b1 = rs2;
                e.data = f3Arith(f3, alt, rs1, rs2); e.we = (rd != 5'd0);
            end
            3'd1: begin
                alt = f7 && (f3 == 3'd5);
                e.c1 = {alt, f3}; e.a1 = rs1; e.b1 = imm;
                e.data = f3Arith(f3, alt, rs1, imm); e.we = (rd != 5'd0);
            end
            3'd2: begin
                e.c1 = 4'b1111; e.b1 = imm; e.chkA1 = 1'b0;
                e.data = imm; e.we = (rd != 5'd0);
            end
            3'd3: begin
                e.a1 = pc; e.b1 = imm; e.data = pc + imm; e.we = (rd != 5'd0);
            end
            3'd4: begin
                case (f3)
                    3'd0:    taken = (rs1 == rs2);
                    3'd1:    taken = (rs1 != rs2);
                    3'd4:    taken = ($signed(rs1) < $signed(rs2));
                    3'd5:    taken = ($signed(rs1) >= $signed(rs2));
                    3'd6:    taken = (rs1 < rs2);
                    3'd7:    taken = (rs1 >= rs2);
                    default: taken = 1'b0;
                endcase
                e.c1 = f3[2] ? (f3[1] ? 4'b0011 : 4'b0010) : 4'b1000;
                e.a1 = rs1; e.b1 = rs2;
                e.chkAlu1 = f3[2] || !f3[1];
                e.chkData = 1'b0;
                e.redir = taken;
                e.npc = taken ? pc + imm : 32'd0;
                e.a2 = pc; e.b2 = imm;
                e.lat = taken ? 2'd3 : 2'd2;
            end
            3'd5, 3'd6: begin
                e.a1 = pc; e.b1 = 32'd4; e.data = pc + 32'd4; e.we = (rd != 5'd0);
                e.redir = 1'b1; e.lat = 2'd3;
                e.a2 = (op == 3'd6) ? rs1 : pc; e.b2 = imm;
                e.npc = (op == 3'd6) ? ((rs1 + imm) & ~32'd1) : pc + imm;
            end
            default: begin
                e.chkData = 1'b0;
            end
        endcase
        return e;
    endfunction

    // Drive one instruction, check every cycle until it retires, then release it.
    task automatic runInstr(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                            input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm, input logic [4:0] rd,
                            input int hold, input bit junk, output expT e);
        e = model(op, f3, f7, pc, rs1, rs2, imm, rd);
        @(negedge clk);
        chk("in_ready before accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_op = op; in_funct3 = f3; in_funct7b5 = f7;
        in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
        out_ready = 1'b0;
        @(negedge clk);
        for (int n = 1; n < int'(e.lat); n++) begin
            in_valid = junk; in_op = 3'($urandom); in_funct3 = 3'($urandom);
            in_pc = $urandom; in_rs1 = $urandom; in_rs2 = $urandom; in_imm = $urandom;
            in_rd = 5'($urandom);
            chk("in_ready busy", {31'd0, in_ready}, 32'd0);
            chk("out_valid early", {31'd0, out_valid}, 32'd0);
            if (n == 1 && e.chkAlu1) begin
                chk("op1 alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.c1});
                if (e.chkA1) chk("op1 alu_in1", alu_in1, e.a1);
                chk("op1 alu_in2", alu_in2, e.b1);
            end
            if (n == 2) begin
                chk("op2 alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
                chk("op2 alu_in1", alu_in1, e.a2);
                chk("op2 alu_in2", alu_in2, e.b2);
            end
            @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("in_ready done", {31'd0, in_ready}, 32'd0);
            chk("alu idle ctrl", {28'd0, alu_ctrl}, 32'd0);
            chk("alu idle in", alu_in1 | alu_in2, 32'd0);
            chk("out_rd", {27'd0, out_rd}, {27'd0, rd});
            chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, e.we});
            chk("out_redirect", {31'd0, out_redirect}, {31'd0, e.redir});
            chk("out_npc", out_npc, e.npc);
            if (e.chkData) chk("out_rd_data", out_rd_data, e.data);
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("in_ready after release", {31'd0, in_ready}, 32'd1);
        chk("out_valid after release", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        expT e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
        in_pc = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_imm = 32'd0; in_rd = 5'd0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_rd_we", {31'd0, out_rd_we}, 32'd0);
        chk("reset out_redirect", {31'd0, out_redirect}, 32'd0);
        chk("reset out_npc", out_npc, 32'd0);
        chk("reset out_rd_data", out_rd_data, 32'd0);
        chk("reset out_rd", {27'd0, out_rd}, 32'd0);
        rst = 1'b0;

        runInstr(3'd0, 3'd0, 1'b1, 32'h0, 32'd5, 32'd7, 32'd0, 5'd3, 0, 1'b0, e);
        chk("pin sub ctrl", {28'd0, e.c1}, 32'h8);
        chk("pin sub data", e.data, 32'hFFFFFFFE);
        chk("pin sub lat", {30'd0, e.lat}, 32'd2);
        runInstr(3'd1, 3'd5, 1'b1, 32'h0, 32'h80000000, 32'd0, 32'd4, 5'd9, 1, 1'b1, e);
        chk("pin srai ctrl", {28'd0, e.c1}, 32'hD);
        chk("pin srai data", e.data, 32'hF8000000);
        runInstr(3'd1, 3'd0, 1'b1, 32'h0, 32'd1, 32'd0, 32'hFFFFFFFF, 5'd4, 0, 1'b0, e);
        chk("pin addi ctrl", {28'd0, e.c1}, 32'h0);
        chk("pin addi data", e.data, 32'd0);
        runInstr(3'd4, 3'd6, 1'b0, 32'h80000010, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF0, 5'd2, 0, 1'b0, e);
        chk("pin bltu npc", e.npc, 32'h80000000);
        chk("pin bltu lat", {30'd0, e.lat}, 32'd3);
        runInstr(3'd4, 3'd4, 1'b0, 32'h80000010, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF0, 5'd2, 0, 1'b0, e);
        chk("pin blt redirect", {31'd0, e.redir}, 32'd0);
        chk("pin blt lat", {30'd0, e.lat}, 32'd2);
        runInstr(3'd6, 3'd0, 1'b0, 32'h80000100, 32'h80001003, 32'd0, 32'd2, 5'd1, 0, 1'b0, e);
        chk("pin jalr data", e.data, 32'h80000104);
        chk("pin jalr npc", e.npc, 32'h80001004);
        runInstr(3'd6, 3'd0, 1'b0, 32'h80000100, 32'h80001003, 32'd0, 32'd2, 5'd0, 0, 1'b0, e);
        chk("pin jalr rd0 we", {31'd0, e.we}, 32'd0);
        runInstr(3'd7, 3'd3, 1'b1, 32'h1234, 32'd8, 32'd9, 32'd10, 5'd7, 5, 1'b1, e);
        runInstr(3'd0, 3'd7, 1'b0, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 5'd31, 5, 1'b1, e);

        // Asynchronous reset while a jal sits in its target pass.
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd5; in_pc = 32'h80000200; in_imm = 32'h40; in_rd = 5'd5;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst-test op2 alu_in1", alu_in1, 32'h80000200);
        #2 rst = 1'b1;
        #1;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst out_redirect", {31'd0, out_redirect}, 32'd0);
        chk("midrst out_npc", out_npc, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("dropped instr no output", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 150; i++) begin
            logic [31:0] r1;
            logic [31:0] r2;
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            runInstr(3'($urandom_range(0, 7)), 3'($urandom), 1'($urandom), $urandom,
                     r1, r2, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
                     1'($urandom), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
